// File: rtl/pipeline_control_pkg.sv
// Shared types for the MIPS pipeline hazard/sequencing controller.
// The optional counters are enabled by PIPE_PERF_CNT_EN.
package pipeline_ctrl_pkg;

    localparam int REGW   = 5;
    localparam int PCNT_W = 32;

    typedef logic [REGW-1:0] regbits_t;

    localparam regbits_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DWAIT  = 2'b01,
        HALTED = 2'b10
    } pctrl_state_t;

endpackage

// File: rtl/pipeline_control_if.sv
// Datapath <-> pipeline controller bundle: stage fields in, register enables/flushes out.
// The datapath is the master; the controller is the slave.
interface pipeline_control_if;
    import pipeline_ctrl_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     exmem_dREN;
    logic     exmem_dWEN;
    logic     idex_dREN;
    regbits_t idex_rt;
    regbits_t ifid_rs;
    regbits_t ifid_rt;
    logic     ifid_uses_rt;
    logic     id_jump;
    logic     ex_redirect;
    logic     memwb_halt;

    logic     pc_en;
    logic     en_ifid, en_idex, en_exmem, en_memwb;
    logic     flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic     halt;

    modport master (
        output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_rt,
               ifid_rs, ifid_rt, ifid_uses_rt, id_jump, ex_redirect, memwb_halt,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb, halt
    );

    modport slave (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_rt,
               ifid_rs, ifid_rt, ifid_uses_rt, id_jump, ex_redirect, memwb_halt,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb, halt
    );

endinterface

// File: rtl/pipeline_control_load_use_detect.sv
// Load-use hazard: the load in ID/EX writes a register the IF/ID instruction reads.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     idex_dREN,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ifid_uses_rt,
    output logic     hazard
);

    // $zero is never a real dependency
    assign hazard = idex_dREN && (idex_rt != REG_ZERO) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_control.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, bubbles, flushes, halt.
// Define PIPE_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
//
// state  | meaning
// RUN    | normal issue
// DWAIT  | data access outstanding, pipeline frozen, bubbles into MEM/WB
// HALTED | halt retired, everything frozen until reset
module pipeline_control
    import pipeline_ctrl_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    pipeline_control_if.slave pif
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PCNT_W-1:0] stall_cnt,
    output logic [PCNT_W-1:0] flush_cnt
`endif
);

    pctrl_state_t state, next_state;
    logic hazard;
    logic dreq;
    logic ihit_eff;
    logic redirect_act;
    logic pc_en;
    logic en_ifid, en_idex, en_exmem, en_memwb;
    logic flush_ifid, flush_idex, flush_exmem, flush_memwb;

    load_use_detect u_lud (
        .idex_dREN    (pif.idex_dREN),
        .idex_rt      (pif.idex_rt),
        .ifid_rs      (pif.ifid_rs),
        .ifid_rt      (pif.ifid_rt),
        .ifid_uses_rt (pif.ifid_uses_rt),
        .hazard       (hazard)
    );

    // the data side owns the shared memory port, so a fetch cannot complete meanwhile
    assign dreq     = pif.exmem_dREN | pif.exmem_dWEN;
    assign ihit_eff = pif.ihit & ~dreq;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        pc_en        = 1'b0;
        en_ifid      = 1'b0;
        en_idex      = 1'b0;
        en_exmem     = 1'b0;
        en_memwb     = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;
        flush_memwb  = 1'b0;
        redirect_act = 1'b0;
        if (RST) begin
            next_state  = RUN;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if (state == HALTED) begin
            next_state = HALTED;
        end else if (pif.memwb_halt) begin
            next_state  = HALTED;
            flush_memwb = 1'b1;
        end else if (dreq && !pif.dhit) begin
            next_state  = DWAIT;
            en_memwb    = 1'b1;
            flush_memwb = 1'b1;
        end else begin
            next_state = RUN;
            pc_en      = 1'b1;
            en_ifid    = 1'b1;
            en_idex    = 1'b1;
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
            if (hazard) begin
                pc_en      = 1'b0;
                en_ifid    = 1'b0;
                flush_idex = 1'b1;
            end else if (pif.ex_redirect) begin
                flush_ifid   = 1'b1;
                flush_idex   = 1'b1;
                redirect_act = 1'b1;
            end else if (pif.id_jump) begin
                flush_ifid   = 1'b1;
                redirect_act = 1'b1;
            end else if (!ihit_eff) begin
                pc_en      = 1'b0;
                flush_ifid = 1'b1;
            end
        end
    end

    assign pif.pc_en       = pc_en;
    assign pif.en_ifid     = en_ifid;
    assign pif.en_idex     = en_idex;
    assign pif.en_exmem    = en_exmem;
    assign pif.en_memwb    = en_memwb;
    assign pif.flush_ifid  = flush_ifid;
    assign pif.flush_idex  = flush_idex;
    assign pif.flush_exmem = flush_exmem;
    assign pif.flush_memwb = flush_memwb;
    assign pif.halt        = (state == HALTED);

`ifdef PIPE_PERF_CNT_EN
    // saturating counters, frozen once halted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != HALTED) begin
            if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (redirect_act && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed vector bench for pipeline_control; PIPE_PERF_CNT_EN adds counter checks.
module tb_pipeline_control;
    import pipeline_ctrl_pkg::*;

    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    pipeline_control_if pif ();

`ifdef PIPE_PERF_CNT_EN
    logic [PCNT_W-1:0] stall_cnt, flush_cnt;
    logic [PCNT_W-1:0] stall_snap, flush_snap;
`endif

    pipeline_control dut (
        .CLK (CLK),
        .RST (RST),
        .pif (pif)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       ihit, dhit, dren, dwen, idex_dren;
        logic [4:0] idex_rt, rs, rt;
        logic       uses_rt, jump, redir;
        logic [8:0] exp;   // {pc_en, en_ifid/idex/exmem/memwb, flush_ifid/idex/exmem/memwb}
    } vec_t;

    vec_t vecs[13];

    function automatic logic [8:0] outs();
        return {pif.pc_en, pif.en_ifid, pif.en_idex, pif.en_exmem, pif.en_memwb,
                pif.flush_ifid, pif.flush_idex, pif.flush_exmem, pif.flush_memwb};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle();
        pif.ihit = 1'b1; pif.dhit = 1'b0; pif.exmem_dREN = 1'b0; pif.exmem_dWEN = 1'b0;
        pif.idex_dREN = 1'b0; pif.idex_rt = '0; pif.ifid_rs = '0; pif.ifid_rt = '0;
        pif.ifid_uses_rt = 1'b0; pif.id_jump = 1'b0; pif.ex_redirect = 1'b0;
        pif.memwb_halt = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        pif.ihit = v.ihit; pif.dhit = v.dhit; pif.exmem_dREN = v.dren; pif.exmem_dWEN = v.dwen;
        pif.idex_dREN = v.idex_dren; pif.idex_rt = v.idex_rt; pif.ifid_rs = v.rs;
        pif.ifid_rt = v.rt; pif.ifid_uses_rt = v.uses_rt; pif.id_jump = v.jump;
        pif.ex_redirect = v.redir; pif.memwb_halt = 1'b0;
    endtask

    initial begin
        //          name            ihit dhit dren dwen ldr  idrt rs  rt  urt jmp red  expected
        vecs[0]  = '{"normal",        1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 9'b1_1111_0000};
        vecs[1]  = '{"imiss",         0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 9'b0_1111_1000};
        vecs[2]  = '{"lu_rs",         1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 9'b0_0111_0100};
        vecs[3]  = '{"lu_zero",       1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 9'b1_1111_0000};
        vecs[4]  = '{"lu_rt",         1, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 9'b0_0111_0100};
        vecs[5]  = '{"lu_rt_unused",  1, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 9'b1_1111_0000};
        vecs[6]  = '{"redir_imiss",   0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 9'b1_1111_1100};
        vecs[7]  = '{"redir_jump",    0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 9'b1_1111_1100};
        vecs[8]  = '{"jump",          1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 9'b1_1111_1000};
        vecs[9]  = '{"lu_over_redir", 1, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 1, 9'b0_0111_0100};
        vecs[10] = '{"dwait_prio",    1, 0, 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 1, 9'b0_0001_0001};
        vecs[11] = '{"dwait_store",   1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 9'b0_0001_0001};
        vecs[12] = '{"resume",        1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 9'b1_1111_0000};

        idle();
        RST = 1'b1;
        #2;
        chk("reset_outs", 32'(outs()), 32'(9'b0_0000_1111));
        chk("reset_halt", 32'(pif.halt), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // reset while in DWAIT
        @(negedge CLK);
        pif.exmem_dREN = 1'b1; pif.dhit = 1'b0;
        @(negedge CLK);
        #1 chk("dwait_before_rst", 32'(outs()), 32'(9'b0_0001_0001));
        RST = 1'b1;
        #1 chk("rst_mid_dwait", 32'(outs()), 32'(9'b0_0000_1111));
        chk("rst_mid_dwait_halt", 32'(pif.halt), 32'd0);
        @(negedge CLK);
        idle();
        RST = 1'b0;
        #1 chk("after_rst_run", 32'(outs()), 32'(9'b1_1111_0000));

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            apply(vecs[i]);
            #1 chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // load-use lasts exactly one cycle once the load moves on
        @(negedge CLK);
        idle();
        pif.idex_dREN = 1'b1; pif.idex_rt = 5'd8; pif.ifid_rs = 5'd8;
        #1 chk("lu_stall", 32'(outs()), 32'(9'b0_0111_0100));
        @(negedge CLK);
        pif.idex_dREN = 1'b0; pif.idex_rt = 5'd0;
        #1 chk("lu_released", 32'(outs()), 32'(9'b1_1111_0000));

        // three data wait cycles then completion
        @(negedge CLK);
        idle();
        pif.exmem_dREN = 1'b1; pif.dhit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("dwait_%0d", c), 32'(outs()), 32'(9'b0_0001_0001));
            @(negedge CLK);
        end
        pif.dhit = 1'b1;
        #1 chk("dhit_enables", 32'({pif.en_ifid, pif.en_idex, pif.en_exmem, pif.en_memwb}), 32'h0000_000f);
        chk("dhit_no_bubble", 32'(pif.flush_memwb), 32'd0);
        @(negedge CLK);
        idle();
        #1 chk("dwait_to_run", 32'(outs()), 32'(9'b1_1111_0000));

        // halt is sticky
        @(negedge CLK);
        pif.memwb_halt = 1'b1;
        #1 chk("halt_cycle", 32'(outs()), 32'(9'b0_0000_0001));
        chk("halt_not_yet", 32'(pif.halt), 32'd0);
        @(posedge CLK);
        #1 chk("halt_set", 32'(pif.halt), 32'd1);
`ifdef PIPE_PERF_CNT_EN
        stall_snap = stall_cnt;
        flush_snap = flush_cnt;
`endif
        pif.memwb_halt = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            pif.ihit = c[0]; pif.dhit = ~c[0]; pif.exmem_dREN = c[1];
            pif.ex_redirect = c[0];
            #1 chk($sformatf("halted_%0d", c), 32'({outs(), pif.halt}), 32'(10'b0_0000_0000_1));
        end
`ifdef PIPE_PERF_CNT_EN
        chk("stall_frozen", stall_cnt, stall_snap);
        chk("flush_frozen", flush_cnt, flush_snap);
`endif

        @(negedge CLK);
        idle();
        RST = 1'b1;
        #1 chk("rst_from_halt", 32'(pif.halt), 32'd0);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt_rst", stall_cnt, 32'd0);
        // stall each cycle, redirect counted once
        @(negedge CLK);
        RST = 1'b0;
        pif.ihit = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        pif.ihit = 1'b1; pif.id_jump = 1'b1;
        @(negedge CLK);
        pif.id_jump = 1'b0;
        #1 chk("stall_cnt_count", stall_cnt, 32'd2);
        chk("flush_cnt_count", flush_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central hazard/sequencing controller for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Handles imem/dmem wait stalls on the shared memory port, load-use bubbles, jump/branch redirect flushes and the sticky halt.
- Sits beside the datapath; consumes stage fields already carried in the pipeline registers.

Parameters:
- REGW, 5, register-index width (rs/rt).
- PCNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- exmem_dREN  in  1  EX/MEM holds a load.
- exmem_dWEN  in  1  EX/MEM holds a store.
- idex_dREN  in  1  ID/EX holds a load.
- idex_rt  in  REGW  load destination in ID/EX.
- ifid_rs  in  REGW  rs of the instruction in IF/ID.
- ifid_rt  in  REGW  rt of the instruction in IF/ID.
- ifid_uses_rt  in  1  IF/ID instruction reads rt.
- id_jump  in  1  J/JAL/JR resolved in ID.
- ex_redirect  in  1  taken branch resolved in EX.
- memwb_halt  in  1  halt instruction reached MEM/WB.
- pc_en  out  1  PC write enable.
- en_ifid, en_idex, en_exmem, en_memwb  out  1 each  register enables.
- flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1 each  synchronous clear; wins over enable in the register.
- halt  out  1  sticky halted indication (registered).

Behaviour:
- Reset (RST=1, async): state=RUN, halt=0. All en_* and pc_en are 0 and all flush_* are 1 while RST is high.
- FSM states: RUN, DWAIT, HALTED. The enum is 2 bits.
- dreq = exmem_dREN | exmem_dWEN. The data request owns the memory port, so ihit is ignored while dreq=1.
- Outputs are combinational from state and inputs.
- Conditions are evaluated in RUN/DWAIT in this priority order, first match wins:
  1. memwb_halt=1: all en_*=0, pc_en=0, flush_memwb=1. Next state is HALTED; halt=1 from the next edge.
  2. dreq & ~dhit: pc_en=0 and en_ifid/en_idex/en_exmem=0. en_memwb=1 with flush_memwb=1 (one bubble per wait cycle, no duplicate writeback). Next state is DWAIT.
  3. Load-use: idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)). Result: pc_en=0, en_ifid=0, flush_idex=1, other enables 1. Exactly one bubble, because the load leaves ID/EX next cycle.
  4. ex_redirect: pc_en=1 (PC takes target), flush_ifid=1, flush_idex=1, other enables 1. This happens regardless of ihit.
  5. id_jump: pc_en=1, flush_ifid=1, other enables 1.
  6. ~ihit: pc_en=0, flush_ifid=1 (bubble into IF/ID), downstream enables 1.
  7. Otherwise: all enables 1, no flush.
- DWAIT: the same priority applies. When dhit=1, the pipeline advances that cycle and the next state is RUN.
- HALTED: absorbing until RST. All en_*=0, pc_en=0, flush_*=0, halt=1.
- Simultaneous events:
  - ex_redirect plus load-use: load-use wins. The branch in ID/EX is replaced by a bubble? No — the branch sits in EX while the stalled load-user is in ID, so ex_redirect stays asserted next cycle and is serviced then.
  - ex_redirect plus id_jump: the redirect wins; the jump is flushed.
- Reset mid-DWAIT or mid-HALTED returns to RUN immediately.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, the block adds outputs stall_cnt [PCNT_W] and flush_cnt [PCNT_W], both reset to 0.
  - stall_cnt increments each cycle pc_en=0 in RUN/DWAIT.
  - flush_cnt increments on each cycle with rule 4 or rule 5 active.
  - Both counters saturate at all-ones and freeze in HALTED.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - the pctrl_state_t enum (RUN, DWAIT, HALTED);
  - the regbits_t typedef (REGW bits);
  - the REG_ZERO constant.
- Sub-module load_use_detect: purely combinational, inputs idex_dREN/idex_rt/ifid_rs/ifid_rt/ifid_uses_rt, output hazard.

Test Plan:
- Reset: assert RST mid-DWAIT -> state RUN, halt=0, flush_*=1, en_*=0; after release with ihit=1 -> all en_*=1.
- Load-use: idex_dREN=1, idex_rt=8, ifid_rs=8 -> one cycle of pc_en=0, en_ifid=0, flush_idex=1. With idex_rt=0 instead -> no stall.
- Dmem wait: exmem_dREN=1, dhit low for 3 cycles -> 3 cycles of frozen pipeline with flush_memwb=1 and state DWAIT; dhit=1 on cycle 4 -> all enables 1, state RUN.
- Redirect: ex_redirect=1 with ihit=0 -> pc_en=1, flush_ifid=1, flush_idex=1. Same cycle with id_jump=1 -> identical response.
- Priority: dreq&~dhit with load-use and ex_redirect all active -> rule 2 response only.
- Halt: memwb_halt=1 -> halt=1 next edge; state stays HALTED with all en_*=0 for 10 cycles despite ihit/dhit toggling. With PIPE_PERF_CNT_EN, counters freeze.
